// File: rtl/spm_arbiter_if.sv
// Requester and SPM-side signal bundle for spm_arbiter.
// The arbiter takes the slave view; the requesters plus SPM array take the master view.
interface spm_arbiter_if #(
  parameter int ADDR_W = 12
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_gnt;
  logic              if_rdy;
  logic [31:0]       if_rd_data;

  logic              mem_req;
  logic              mem_rw;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wr_data;
  logic              mem_gnt;
  logic              mem_rdy;
  logic [31:0]       mem_rd_data;

  logic              bus_req;
  logic              bus_rw;
  logic [31:0]       bus_addr;
  logic [31:0]       bus_wr_data;
  logic              bus_gnt;
  logic              bus_rdy;
  logic [31:0]       bus_rd_data;

  logic              spm_as_;
  logic              spm_rw;
  logic [ADDR_W-1:0] spm_addr;
  logic [31:0]       spm_wr_data;
  logic [31:0]       spm_rd_data;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rdy, if_rd_data,
    input  mem_req, mem_rw, mem_addr, mem_wr_data,
    output mem_gnt, mem_rdy, mem_rd_data,
    input  bus_req, bus_rw, bus_addr, bus_wr_data,
    output bus_gnt, bus_rdy, bus_rd_data,
    output spm_as_, spm_rw, spm_addr, spm_wr_data,
    input  spm_rd_data
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rdy, if_rd_data,
    output mem_req, mem_rw, mem_addr, mem_wr_data,
    input  mem_gnt, mem_rdy, mem_rd_data,
    output bus_req, bus_rw, bus_addr, bus_wr_data,
    input  bus_gnt, bus_rdy, bus_rd_data,
    input  spm_as_, spm_rw, spm_addr, spm_wr_data,
    output spm_rd_data
  );
endinterface

// File: rtl/spm_arbiter.sv
// Single-port scratch pad arbiter: IF / MEM / bus share one SPM port with 1-cycle reads.
// One access per cycle; the owner register routes the returning rdy/data to the winner.
module spm_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input logic          clk,
  input logic          reset_,
  spm_arbiter_if.slave sif
);

  localparam logic READ = 1'b1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2,
    OWN_BUS  = 2'd3
  } owner_t;

  owner_t             owner_reg, owner_next;
  logic [CNT_W-1:0]   starve_cnt_reg, starve_cnt_next;
  logic               promoted;

  logic               if_gnt_next, mem_gnt_next, bus_gnt_next;
  logic               spm_as_next;
  logic               spm_rw_next;
  logic [ADDR_W-1:0]  spm_addr_next;
  logic [31:0]        spm_wr_data_next;

  // Upper address bits are intentionally ignored (word address wraps inside the SPM).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{sif.if_addr[31:ADDR_W], sif.mem_addr[31:ADDR_W],
                              sif.bus_addr[31:ADDR_W]};

  assign promoted = (starve_cnt_reg == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      owner_reg      <= OWN_NONE;
      starve_cnt_reg <= '0;
    end else begin
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  // Grant selection and SPM command; reset_ gates everything so gnts stay low in reset.
  always_comb begin
    owner_next       = OWN_NONE;
    if_gnt_next      = 1'b0;
    mem_gnt_next     = 1'b0;
    bus_gnt_next     = 1'b0;
    spm_as_next      = 1'b1;
    spm_rw_next      = READ;
    spm_addr_next    = '0;
    spm_wr_data_next = '0;

    if (reset_) begin
      if (promoted && sif.if_req) begin
        owner_next = OWN_IF;
      end else if (sif.mem_req) begin
        owner_next = OWN_MEM;
      end else if (sif.bus_req) begin
        owner_next = OWN_BUS;
      end else if (sif.if_req) begin
        owner_next = OWN_IF;
      end
    end

    case (owner_next)
      OWN_IF: begin
        if_gnt_next   = 1'b1;
        spm_as_next   = 1'b0;
        spm_rw_next   = READ;
        spm_addr_next = sif.if_addr[ADDR_W-1:0];
      end
      OWN_MEM: begin
        mem_gnt_next     = 1'b1;
        spm_as_next      = 1'b0;
        spm_rw_next      = sif.mem_rw;
        spm_addr_next    = sif.mem_addr[ADDR_W-1:0];
        spm_wr_data_next = sif.mem_wr_data;
      end
      OWN_BUS: begin
        bus_gnt_next     = 1'b1;
        spm_as_next      = 1'b0;
        spm_rw_next      = sif.bus_rw;
        spm_addr_next    = sif.bus_addr[ADDR_W-1:0];
        spm_wr_data_next = sif.bus_wr_data;
      end
      default: ;
    endcase
  end

  // Starvation counter saturates so promotion persists until IF is actually served.
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!sif.if_req || if_gnt_next) begin
      starve_cnt_next = '0;
    end else if (!promoted) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  assign sif.if_gnt      = if_gnt_next;
  assign sif.mem_gnt     = mem_gnt_next;
  assign sif.bus_gnt     = bus_gnt_next;
  assign sif.spm_as_     = spm_as_next;
  assign sif.spm_rw      = spm_rw_next;
  assign sif.spm_addr    = spm_addr_next;
  assign sif.spm_wr_data = spm_wr_data_next;

  assign sif.if_rdy      = (owner_reg == OWN_IF);
  assign sif.mem_rdy     = (owner_reg == OWN_MEM);
  assign sif.bus_rdy     = (owner_reg == OWN_BUS);
  assign sif.if_rd_data  = sif.if_rdy  ? sif.spm_rd_data : 32'h0;
  assign sif.mem_rd_data = sif.mem_rdy ? sif.spm_rd_data : 32'h0;
  assign sif.bus_rd_data = sif.bus_rdy ? sif.spm_rd_data : 32'h0;

endmodule

// File: tb/tb_spm_arbiter.sv
// Bench for spm_arbiter: directed stimulus pushes expected rdy cycle/data per requester,
// a negedge monitor pops and compares; an SPM array model sits on the memory side.
module tb_spm_arbiter;

  logic clk;
  logic reset_;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  spm_arbiter_if #(.ADDR_W(12)) sif ();

  spm_arbiter #(.ADDR_W(12), .STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk    (clk),
    .reset_ (reset_),
    .sif    (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous SPM array: write on strobe, read data registered one cycle later.
  logic [31:0] spm_mem [0:4095];
  always @(posedge clk) begin
    if (!sif.spm_as_) begin
      if (sif.spm_rw) sif.spm_rd_data <= spm_mem[sif.spm_addr];
      else            spm_mem[sif.spm_addr] <= sif.spm_wr_data;
    end
  end

  typedef struct {
    int          cyc;
    logic [31:0] data;
    bit          chk;
  } exp_t;

  exp_t  q [3][$];
  string nm [3] = '{"if", "mem", "bus"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int ch, input logic [31:0] data, input bit chk);
    exp_t e;
    e.cyc  = cyc + 1;
    e.data = data;
    e.chk  = chk;
    q[ch].push_back(e);
  endtask

  task automatic chan(input int ch, input logic rdy, input logic [31:0] d);
    exp_t e;
    if (rdy === 1'b1) begin
      if (q[ch].size() == 0) begin
        check({nm[ch], "_rdy_unexpected"}, 32'(rdy), 32'h0);
      end else begin
        e = q[ch].pop_front();
        check({nm[ch], "_rdy_cycle"}, 32'(cyc), 32'(e.cyc));
        if (e.chk) check({nm[ch], "_rd_data"}, d, e.data);
        $display("txn %s rdy cyc=%0d data=%h", nm[ch], cyc, d);
      end
    end else begin
      check({nm[ch], "_rd_data_idle"}, d, 32'h0);
      if (q[ch].size() != 0 && q[ch][0].cyc <= cyc) begin
        check({nm[ch], "_rdy_missing"}, 32'(rdy), 32'h1);
        void'(q[ch].pop_front());
      end
    end
  endtask

  always @(negedge clk) begin
    chan(0, sif.if_rdy,  sif.if_rd_data);
    chan(1, sif.mem_rdy, sif.mem_rd_data);
    chan(2, sif.bus_rdy, sif.bus_rd_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_reqs();
    sif.if_req  = 1'b0;
    sif.mem_req = 1'b0;
    sif.bus_req = 1'b0;
  endtask

  task automatic mem_write(input logic [31:0] addr, input logic [31:0] data);
    tick();
    idle_reqs();
    sif.mem_req = 1'b1; sif.mem_rw = 1'b0; sif.mem_addr = addr; sif.mem_wr_data = data;
    @(negedge clk);
    check("preload_mem_gnt", 32'(sif.mem_gnt), 32'h1);
    push(1, 32'h0, 1'b0);
    $display("txn mem write addr=%h data=%h", addr, data);
  endtask

  task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp);
    tick();
    idle_reqs();
    sif.bus_req = 1'b1; sif.bus_rw = 1'b1; sif.bus_addr = addr;
    @(negedge clk);
    check("bus_read_gnt", 32'(sif.bus_gnt), 32'h1);
    push(2, exp, 1'b1);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset_ = 1'b0;
    sif.if_req = 1'b1; sif.if_addr = 32'h0;
    sif.mem_req = 1'b1; sif.mem_rw = 1'b1; sif.mem_addr = 32'h0; sif.mem_wr_data = 32'h0;
    sif.bus_req = 1'b1; sif.bus_rw = 1'b1; sif.bus_addr = 32'h0; sif.bus_wr_data = 32'h0;

    // Reset state with all requests high: no grant may leak through.
    repeat (2) @(negedge clk);
    check("rst_if_gnt",   32'(sif.if_gnt),  32'h0);
    check("rst_mem_gnt",  32'(sif.mem_gnt), 32'h0);
    check("rst_bus_gnt",  32'(sif.bus_gnt), 32'h0);
    check("rst_spm_as_",  32'(sif.spm_as_), 32'h1);
    check("rst_spm_rw",   32'(sif.spm_rw),  32'h1);
    check("rst_spm_addr", 32'(sif.spm_addr), 32'h0);
    check("rst_spm_wd",   sif.spm_wr_data,  32'h0);
    tick();
    idle_reqs();
    reset_ = 1'b1;

    mem_write(32'h10, 32'hDEADBEEF);
    mem_write(32'h30, 32'h30303030);
    mem_write(32'h40, 32'h40404040);
    mem_write(32'h50, 32'h50505050);
    mem_write(32'h05, 32'h55555555);
    tick();
    idle_reqs();

    // Single IF read.
    tick();
    sif.if_req = 1'b1; sif.if_addr = 32'h10;
    @(negedge clk);
    check("single_if_gnt",   32'(sif.if_gnt),   32'h1);
    check("single_spm_as_",  32'(sif.spm_as_),  32'h0);
    check("single_spm_addr", 32'(sif.spm_addr), 32'h010);
    check("single_spm_rw",   32'(sif.spm_rw),   32'h1);
    push(0, 32'hDEADBEEF, 1'b1);
    tick();
    idle_reqs();

    // Priority: MEM > BUS > IF with all three arriving together.
    tick();
    sif.mem_req = 1'b1; sif.mem_rw = 1'b0; sif.mem_addr = 32'h20; sif.mem_wr_data = 32'h12345678;
    sif.bus_req = 1'b1; sif.bus_rw = 1'b1; sif.bus_addr = 32'h30;
    sif.if_req  = 1'b1; sif.if_addr = 32'h40;
    @(negedge clk);
    check("prio0_mem_gnt",  32'(sif.mem_gnt),  32'h1);
    check("prio0_bus_gnt",  32'(sif.bus_gnt),  32'h0);
    check("prio0_if_gnt",   32'(sif.if_gnt),   32'h0);
    check("prio0_spm_rw",   32'(sif.spm_rw),   32'h0);
    check("prio0_spm_addr", 32'(sif.spm_addr), 32'h020);
    check("prio0_spm_wd",   sif.spm_wr_data,   32'h12345678);
    push(1, 32'h0, 1'b0);
    tick();
    sif.mem_req = 1'b0;
    @(negedge clk);
    check("prio1_bus_gnt",  32'(sif.bus_gnt),  32'h1);
    check("prio1_if_gnt",   32'(sif.if_gnt),   32'h0);
    check("prio1_spm_addr", 32'(sif.spm_addr), 32'h030);
    push(2, 32'h30303030, 1'b1);
    tick();
    sif.bus_req = 1'b0;
    @(negedge clk);
    check("prio2_if_gnt",   32'(sif.if_gnt),   32'h1);
    check("prio2_spm_addr", 32'(sif.spm_addr), 32'h040);
    push(0, 32'h40404040, 1'b1);
    bus_read(32'h20, 32'h12345678);
    tick();
    idle_reqs();

    // Starvation: IF denied 4 cycles, then promoted above a persistent MEM.
    tick();
    sif.if_req  = 1'b1; sif.if_addr = 32'h40;
    sif.mem_req = 1'b1; sif.mem_rw = 1'b1; sif.mem_addr = 32'h50;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("starve_if_denied", 32'(sif.if_gnt),  32'h0);
      check("starve_mem_gnt",   32'(sif.mem_gnt), 32'h1);
      push(1, 32'h50505050, 1'b1);
      tick();
    end
    @(negedge clk);
    check("starve_if_promoted", 32'(sif.if_gnt),  32'h1);
    check("starve_mem_held",    32'(sif.mem_gnt), 32'h0);
    push(0, 32'h40404040, 1'b1);
    tick();
    @(negedge clk);
    check("starve_cleared_mem", 32'(sif.mem_gnt), 32'h1);
    check("starve_cleared_if",  32'(sif.if_gnt),  32'h0);
    push(1, 32'h50505050, 1'b1);
    tick();
    idle_reqs();

    // MEM write then IF read of the same address in the next cycle.
    tick();
    sif.mem_req = 1'b1; sif.mem_rw = 1'b0; sif.mem_addr = 32'h7; sif.mem_wr_data = 32'hA5A5A5A5;
    @(negedge clk);
    check("wr_rd_mem_gnt", 32'(sif.mem_gnt), 32'h1);
    push(1, 32'h0, 1'b0);
    tick();
    sif.mem_req = 1'b0;
    sif.if_req = 1'b1; sif.if_addr = 32'h7;
    @(negedge clk);
    check("wr_rd_if_gnt", 32'(sif.if_gnt), 32'h1);
    push(0, 32'hA5A5A5A5, 1'b1);
    tick();
    idle_reqs();

    // Reset in the cycle where the bus read would complete: rdy is discarded.
    tick();
    sif.bus_req = 1'b1; sif.bus_rw = 1'b1; sif.bus_addr = 32'h30;
    @(negedge clk);
    check("rstmid_bus_gnt", 32'(sif.bus_gnt), 32'h1);
    tick();
    sif.bus_req = 1'b0;
    sif.if_req  = 1'b1; sif.if_addr = 32'h10;
    reset_ = 1'b0;
    #1;
    check("rstmid_bus_rdy",     32'(sif.bus_rdy),   32'h0);
    check("rstmid_bus_rd_data", sif.bus_rd_data,    32'h0);
    check("rstmid_spm_as_",     32'(sif.spm_as_),   32'h1);
    check("rstmid_if_gnt",      32'(sif.if_gnt),    32'h0);
    tick();
    tick();
    idle_reqs();
    reset_ = 1'b1;
    sif.bus_req = 1'b1; sif.bus_rw = 1'b1; sif.bus_addr = 32'h5;
    @(negedge clk);
    check("rstrel_bus_gnt", 32'(sif.bus_gnt), 32'h1);
    push(2, 32'h55555555, 1'b1);
    tick();
    idle_reqs();

    // Address truncation, and bus request withdrawn before it was ever granted.
    tick();
    sif.mem_req = 1'b1; sif.mem_rw = 1'b1; sif.mem_addr = 32'hFFFF_F005;
    sif.bus_req = 1'b1; sif.bus_rw = 1'b1; sif.bus_addr = 32'h10;
    @(negedge clk);
    check("trunc_mem_gnt",  32'(sif.mem_gnt),  32'h1);
    check("trunc_bus_gnt",  32'(sif.bus_gnt),  32'h0);
    check("trunc_spm_addr", 32'(sif.spm_addr), 32'h005);
    push(1, 32'h55555555, 1'b1);
    tick();
    idle_reqs();
    @(negedge clk);
    check("withdraw_spm_as_", 32'(sif.spm_as_), 32'h1);
    check("withdraw_bus_gnt", 32'(sif.bus_gnt), 32'h0);

    repeat (4) tick();
    for (int ch = 0; ch < 3; ch++) begin
      check({nm[ch], "_pending_at_end"}, 32'(q[ch].size()), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/spm_arbiter.md
Name: spm_arbiter

Overview:
- Single-port arbiter and sequencer for the scratch pad memory.
- Shares one synchronous SPM port (1-cycle read latency) between three requesters: IF fetch (read-only), MEM load/store, and an external bus master (DMA/debug).
- Sits between the pipeline/bus and the SPM array.
- Issues at most one SPM access per cycle and returns read data with a ready pulse.

Parameters:
- ADDR_W, 12, SPM word-address width; SPM depth is 2^ADDR_W words.
- STARVE_LIMIT, 4, consecutive denied IF cycles before IF is promoted to top priority.
- CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset_  in  1  asynchronous, active-low reset
- if_req  in  1  IF read request, held until if_gnt
- if_addr  in  32  IF word address, low ADDR_W bits used
- if_gnt  out  1  IF request accepted this cycle
- if_rdy  out  1  IF read data valid (cycle after if_gnt)
- if_rd_data  out  32  IF read data
- mem_req  in  1  MEM request, held until mem_gnt
- mem_rw  in  1  `READ=1 / `WRITE=0
- mem_addr  in  32  MEM word address
- mem_wr_data  in  32  MEM write data
- mem_gnt  out  1  MEM accepted
- mem_rdy  out  1  MEM access complete / read data valid
- mem_rd_data  out  32  MEM read data
- bus_req, bus_rw, bus_addr, bus_wr_data  in  1/1/32/32  bus master request, same rules as MEM
- bus_gnt, bus_rdy  out  1  bus accepted / complete
- bus_rd_data  out  32  bus read data
- spm_as_  out  1  SPM address strobe, active-low
- spm_rw  out  1  SPM read/write
- spm_addr  out  ADDR_W  SPM word address
- spm_wr_data  out  32  SPM write data
- spm_rd_data  in  32  SPM read data, valid one cycle after strobe

Behaviour:
- **Arbitration:** combinational within cycle N over current requests.
  - Normal priority: MEM > BUS > IF.
  - Promoted mode (starve_cnt == STARVE_LIMIT): IF > MEM > BUS.
  - Exactly one gnt asserted when any req is high; none otherwise.
- **Command:** winner's rw/addr[ADDR_W-1:0]/wr_data drive the spm_* outputs in cycle N with spm_as_=0. When idle: spm_as_=1, spm_rw=`READ, spm_addr=0, spm_wr_data=0.
  - IF grant always issues spm_rw=`READ.
- **Owner register:** {NONE, IF, MEM, BUS}, captured at the clock edge ending cycle N.
  - Cycle N+1: the owner's rdy=1 for exactly one cycle, for reads and writes alike.
  - Owner's rd_data = spm_rd_data while rdy=1, otherwise 0.
  - Non-owner rd_data = 0.
- **Throughput:** back-to-back grants every cycle. A grant in N+1 coexists with rdy for the N access.
- **Starvation counter starve_cnt:**
  - Increments (saturating at STARVE_LIMIT) on each cycle with if_req=1 and if_gnt=0.
  - Clears to 0 on if_gnt or when if_req=0.
- **Requester protocol:** requester holds req and payload stable until gnt. Dropping req before gnt is legal (request withdrawn, no access). A requester may re-request in the cycle after its gnt.
- **Write/read same address:** MEM write in N followed by IF read of that address in N+1 returns the new data (SPM write-before-read ordering across cycles).
- **Reset (reset_=0, asynchronous):**
  - owner=NONE, starve_cnt=0.
  - All gnt/rdy=0, all rd_data=0, spm_as_=1, spm_addr=0, spm_wr_data=0, spm_rw=`READ.
  - Gnts are forced low during reset regardless of req.
  - Reset mid-access discards the pending rdy; no rdy pulse after reset release.
  - First grant is possible in the first cycle with reset_=1.

Test Plan:
- Single IF read:
  - Preload SPM[0x010]=0xDEADBEEF.
  - if_req=1, if_addr=0x10 in cycle 5.
  - Required: if_gnt=1 in cycle 5; spm_as_=0, spm_addr=0x010 in cycle 5; if_rdy=1 and if_rd_data=0xDEADBEEF in cycle 6; if_rdy=0 in cycle 7.
- Priority:
  - MEM write (addr 0x20, data 0x12345678), bus read (0x30) and IF read (0x40) all requested in cycle 10.
  - Required: mem_gnt in cycle 10, bus_gnt in 11, if_gnt in 12; mem_rdy in 11, bus_rdy in 12, if_rdy in 13.
- Starvation, STARVE_LIMIT=4:
  - IF and MEM request continuously (MEM re-requests every cycle).
  - Required: if_gnt=0 for 4 cycles, if_gnt=1 in the 5th cycle with mem_gnt=0 that cycle, starve_cnt=0 afterwards.
- Write then read same address:
  - MEM write 0xA5A5A5A5 to 0x7 in cycle N; IF read 0x7 in cycle N+1.
  - Required: if_rd_data=0xA5A5A5A5 with if_rdy in cycle N+2.
- Reset mid-access:
  - Bus read granted in cycle N; reset_ low in cycle N+1, before the edge.
  - Required: bus_rdy=0 and bus_rd_data=0 immediately; spm_as_=1; no rdy after release.
  - First request after release is granted in the same cycle.
- Address truncation / withdrawal:
  - mem_addr=0xFFFF_F005 gives spm_addr=0x005.
  - bus_req dropped before grant gives no spm_as_ and no bus_rdy.
